// File: rtl/univ_shift_reg_pkg.sv
// Shared constants for the universal shift register: mode codes,
// burst FSM state encoding and burst direction values.
package shift_reg_pkg;

  // Operation select codes presented on the mode input
  localparam logic [2:0] MODE_HOLD  = 3'd0;
  localparam logic [2:0] MODE_LOAD  = 3'd1;
  localparam logic [2:0] MODE_SHL   = 3'd2;
  localparam logic [2:0] MODE_SHR   = 3'd3;
  localparam logic [2:0] MODE_ROL   = 3'd4;
  localparam logic [2:0] MODE_ROR   = 3'd5;
  localparam logic [2:0] MODE_BURST = 3'd6;
  localparam logic [2:0] MODE_CLEAR = 3'd7;

  // Burst controller states
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } burst_state_e;

  // Burst shift direction
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/univ_shift_reg_if.sv
// Bundles the control/data inputs and the register outputs of the
// universal shift register. The master side drives commands, the slave
// side is the register itself.
interface univ_shift_reg_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             ser_in;
  logic             dir;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_not;
  logic             ser_out_msb;
  logic             ser_out_lsb;
  logic             busy;
  logic             done;

  modport master (
    output en, mode, d, ser_in, dir, count,
    input  q, q_not, ser_out_msb, ser_out_lsb, busy, done
  );

  modport slave (
    input  en, mode, d, ser_in, dir, count,
    output q, q_not, ser_out_msb, ser_out_lsb, busy, done
  );
endinterface

// File: rtl/univ_shift_reg_burst_ctrl.sv
// Burst controller: latches the shift count and direction at burst start,
// issues one shift strobe per enabled cycle, and raises a one-cycle done
// pulse after the final shift (or immediately for a zero-length burst).
module shift_burst_ctrl
  import shift_reg_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_en,
  input  logic             i_start,
  input  logic             i_clear,
  input  logic             i_dir,
  input  logic [CNT_W-1:0] i_count,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_shift_strobe,
  output logic             o_shift_dir
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  burst_state_e     r_state;
  burst_state_e     w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_dir;
  logic             w_dir_nxt;
  logic             r_done;
  logic             w_done_nxt;

  // State, counter, latched direction and done pulse registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= CNT_ZERO;
      r_dir   <= DIR_LEFT;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dir   <= w_dir_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state logic: everything holds while disabled, done only pulses
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;
    w_done_nxt  = 1'b0;
    if (i_en) begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            if (i_count != CNT_ZERO) begin
              w_state_nxt = ST_BURST;
              w_cnt_nxt   = i_count;
              w_dir_nxt   = i_dir;
            end else begin
              w_done_nxt  = 1'b1;
            end
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_BURST: begin
          if (i_clear) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = CNT_ZERO;
          end else begin
            // Decrement never wraps below zero
            if (r_cnt != CNT_ZERO) begin
              w_cnt_nxt = r_cnt - CNT_ONE;
            end else begin
              w_cnt_nxt = CNT_ZERO;
            end
            if (r_cnt <= CNT_ONE) begin
              w_state_nxt = ST_IDLE;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = ST_BURST;
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = CNT_ZERO;
        end
      endcase
    end else begin
      w_done_nxt = 1'b0;
    end
  end

  // Outputs to the datapath and the handshake pins
  always_comb begin
    o_busy         = (r_state == ST_BURST);
    o_done         = r_done;
    o_shift_dir    = r_dir;
    o_shift_strobe = i_en && (r_state == ST_BURST) && !i_clear;
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold / load / shift / rotate / clear plus a
// multi-cycle burst shift sequenced by shift_burst_ctrl. q_not and the
// serial outputs are decoded directly from q so they can never disagree.
module univ_shift_reg
  import shift_reg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               CNT_W     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic          clock,
  input  logic          reset,
  univ_shift_reg_if.slave bus
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_busy;
  logic             w_done;
  logic             w_shift_strobe;
  logic             w_shift_dir;
  logic             w_start;
  logic             w_clear;

  assign w_start = (bus.mode == MODE_BURST);
  assign w_clear = (bus.mode == MODE_CLEAR);

  shift_burst_ctrl #(
    .CNT_W (CNT_W)
  ) u_burst_ctrl (
    .clock          (clock),
    .reset          (reset),
    .i_en           (bus.en),
    .i_start        (w_start),
    .i_clear        (w_clear),
    .i_dir          (bus.dir),
    .i_count        (bus.count),
    .o_busy         (w_busy),
    .o_done         (w_done),
    .o_shift_strobe (w_shift_strobe),
    .o_shift_dir    (w_shift_dir)
  );

  // Mode mux: during a burst only CLEAR and the burst strobe act on q
  always_comb begin
    w_q_nxt = r_q;
    if (!bus.en) begin
      w_q_nxt = r_q;
    end else if (w_busy) begin
      if (w_clear) begin
        w_q_nxt = {WIDTH{1'b0}};
      end else if (w_shift_strobe) begin
        if (w_shift_dir == DIR_RIGHT) begin
          w_q_nxt = {bus.ser_in, r_q[WIDTH-1:1]};
        end else begin
          w_q_nxt = {r_q[WIDTH-2:0], bus.ser_in};
        end
      end else begin
        w_q_nxt = r_q;
      end
    end else begin
      case (bus.mode)
        MODE_HOLD:  w_q_nxt = r_q;
        MODE_LOAD:  w_q_nxt = bus.d;
        MODE_SHL:   w_q_nxt = {r_q[WIDTH-2:0], bus.ser_in};
        MODE_SHR:   w_q_nxt = {bus.ser_in, r_q[WIDTH-1:1]};
        MODE_ROL:   w_q_nxt = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        MODE_ROR:   w_q_nxt = {r_q[0], r_q[WIDTH-1:1]};
        MODE_BURST: w_q_nxt = r_q;
        MODE_CLEAR: w_q_nxt = {WIDTH{1'b0}};
        default:    w_q_nxt = r_q;
      endcase
    end
  end

  // Register contents
  always_ff @(posedge clock) begin
    if (reset) begin
      r_q <= RESET_VAL;
    end else begin
      r_q <= w_q_nxt;
    end
  end

  assign bus.q           = r_q;
  assign bus.q_not       = ~r_q;
  assign bus.ser_out_msb = r_q[WIDTH-1];
  assign bus.ser_out_lsb = r_q[0];
  assign bus.busy        = w_busy;
  assign bus.done        = w_done;

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised successor to the team's single-bit D flip-flop: a WIDTH-bit register with true and complementary outputs (q, q_not).
- Supports hold, parallel load, logical shift, rotate and clear.
- Adds a multi-cycle "burst" mode that shifts by a programmed count, one bit per enabled cycle, with busy/done handshake.
- Serves as the general storage/serialisation element for the training designs; sits directly under top.

Parameters:
WIDTH, 8, register width in bits (>=2)
CNT_W, 4, width of burst count input; max burst = 2**CNT_W-1
RESET_VAL, 0, value loaded into q on reset (WIDTH bits)

Ports:
clock  input  1  single clock, rising edge
reset  input  1  synchronous, active-high reset
en  input  1  clock enable; when 0 all state holds, burst paused
mode  input  3  operation select (see Behaviour)
d  input  WIDTH  parallel load data
ser_in  input  1  serial fill bit for shifts (SHL fills bit 0, SHR fills bit WIDTH-1)
dir  input  1  burst direction: 0 = left, 1 = right (rotate-through ser_in fill, i.e. logical shift)
count  input  CNT_W  burst shift amount, sampled at burst start
q  output  WIDTH  register contents
q_not  output  WIDTH  bitwise complement of q, always ~q
ser_out_msb  output  1  q[WIDTH-1]
ser_out_lsb  output  1  q[0]
busy  output  1  high while burst in progress
done  output  1  one-cycle pulse when burst completes

Behaviour:
- All state updates on rising clock; reset synchronous, active-high, highest priority.
- Reset values:
  - q=RESET_VAL, q_not=~RESET_VAL.
  - busy=0, done=0.
  - FSM=IDLE, internal counter=0.
- q_not, ser_out_msb and ser_out_lsb are combinational from q; never registered separately, so q_not==~q every cycle.
- Mode encoding (en=1, FSM IDLE), result visible the cycle after the edge:
  - 0 HOLD: q unchanged
  - 1 LOAD: q<=d
  - 2 SHL: q<={q[WIDTH-2:0],ser_in}
  - 3 SHR: q<={ser_in,q[WIDTH-1:1]}
  - 4 ROL: q<={q[WIDTH-2:0],q[WIDTH-1]}
  - 5 ROR: q<={q[0],q[WIDTH-1:1]}
  - 6 BURST: start burst
  - 7 CLEAR: q<=0
- en=0: q, counter and FSM hold; done forced 0 that cycle.
- FSM states IDLE, BURST:
  - IDLE + en + mode=BURST, count=N>0: latch N and dir; busy=1 from next cycle; no shift on the start edge.
  - IDLE + en + mode=BURST, count=0: stay IDLE; done=1 for exactly one cycle (next cycle); q unchanged; busy never rises.
  - BURST + en: shift one position per cycle per the latched dir, filling with the current ser_in; decrement counter.
  - BURST, last shift (counter 1->0): return to IDLE; busy=0 and done=1 in the cycle after the final shift. q shows the final value in that same cycle.
  - Total from start edge: N shifts over N enabled cycles after the start edge; done appears N+1 enabled cycles after the start edge.
  - BURST: mode ignored except CLEAR.
  - CLEAR in BURST: aborts burst, q<=0, busy<=0; no done pulse.
  - Reset during BURST: aborts; reset values apply; no done pulse.
- done is a single-cycle pulse. A new mode command is accepted in the same cycle done is high (FSM already IDLE), so back-to-back bursts work with no gap.
- Counter arithmetic is unsigned CNT_W bits, with no wrap: decrement occurs only while counter>0.

Decomposition:
- Package shift_reg_pkg:
  - mode localparams MODE_HOLD..MODE_CLEAR (3-bit)
  - FSM state encoding ST_IDLE/ST_BURST
  - DIR_LEFT/DIR_RIGHT constants
- One sub-module, shift_burst_ctrl: FSM, counter, latched dir, busy/done generation. It outputs a one-bit shift_strobe and shift_dir to the datapath.
- Datapath (mode mux + q register) stays in univ_shift_reg.

Test Plan:
- WIDTH=8, reset=1 for 1 cycle with RESET_VAL=8'hA5 -> q=8'hA5, q_not=8'h5A, busy=0, done=0.
- LOAD d=8'h81, then ROL, then ROR -> q=8'h81, 8'h03, 8'h81.
- LOAD 8'hF0, then SHL with ser_in=1, then SHR with ser_in=0 -> q=8'hE1, then 8'h70; ser_out_lsb=0, ser_out_msb=0.
- LOAD 8'h01, BURST count=3 dir=0 ser_in=0, with en=0 for one cycle mid-burst:
  - busy high 4 cycles (3 shifting + 1 paused)
  - q=8'h08 when done pulses
  - done high exactly one cycle
- BURST count=0 -> done pulses next cycle, busy stays 0, q unchanged.
- LOAD 8'hFF, BURST count=5 dir=1:
  - CLEAR after 2 shifts -> q=8'h00, busy=0, no done.
  - Repeat with reset instead of CLEAR -> q=RESET_VAL, no done.
